// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Imported by the format block and the stage top.
package mem_access_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/mem_access_stage_align.sv
// Size/alignment decode, store lane replication and
// load lane extraction with sign/zero extension.
module lsu_align_format
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic [31:0] load_data
);

    logic [31:0] lane;

    // byte enables and alignment; unknown funct3 counts as misaligned
    always_comb begin
        be       = 4'b0000;
        misalign = 1'b1;
        case (funct3)
            F3_LB, F3_LBU: begin
                be       = 4'b0001 << offset;
                misalign = 1'b0;
            end
            F3_LH, F3_LHU: begin
                be       = 4'b0011 << offset;
                misalign = offset[0];
            end
            F3_LW: begin
                be       = 4'b1111;
                misalign = |offset;
            end
            default: begin
                be       = 4'b0000;
                misalign = 1'b1;
            end
        endcase
    end

    // replicate narrow store data across every lane it may land in
    always_comb begin
        wdata = store_data;
        case (funct3)
            F3_SB:   wdata = {4{store_data[7:0]}};
            F3_SH:   wdata = {2{store_data[15:0]}};
            F3_SW:   wdata = store_data;
            default: wdata = store_data;
        endcase
    end

    // shift the addressed lane down, then extend to 32 bits
    always_comb begin
        lane      = rdata >> {offset, 3'b000};
        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
            F3_LBU:  load_data = {24'h0, lane[7:0]};
            F3_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
            F3_LHU:  load_data = {16'h0, lane[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: req/gnt/rvalid bus FSM,
// pipeline stall, timeout fault and formatted load result.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter logic [31:0] RESET_ADDR     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] store_data_i,
    input  logic [2:0]  funct3_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] load_data_o,
    output logic        mem_done_o,
    output logic        misalign_o,
    output logic        access_fault_o,
    output logic        stall_o
);

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q;
    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] load_q;
    logic        fault_q;

    logic        idle;
    logic        op;
    logic        start;
    logic        expired;
    logic        capture;
    logic        to_fault;
    logic [2:0]  sel_f3;
    logic [1:0]  sel_off;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic        fmt_mis;
    logic [31:0] fmt_load;

    assign idle    = (state_q == ST_IDLE);
    assign op      = mem_read_i | mem_write_i;
    assign sel_f3  = idle ? funct3_i : f3_q;
    assign sel_off = idle ? mem_addr_i[1:0] : off_q;
    assign start   = idle & op & ~fmt_mis & ~flush_i;
    assign expired = (cnt_q + 8'd1) == TO_LIM;

    lsu_align_format u_fmt (
        .funct3     (sel_f3),
        .offset     (sel_off),
        .store_data (store_data_i),
        .rdata      (dmem_rdata_i),
        .be         (fmt_be),
        .wdata      (fmt_wdata),
        .misalign   (fmt_mis),
        .load_data  (fmt_load)
    );

    // next state; grant/response win over a same-cycle timeout
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        to_fault = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (dmem_gnt_i) begin
                    if (we_q) begin
                        state_d = ST_DONE;
                    end else if (dmem_rvalid_i) begin
                        state_d = ST_DONE;
                        capture = 1'b1;
                    end else begin
                        state_d = ST_RSP;
                    end
                end else if (expired) begin
                    state_d  = ST_DONE;
                    to_fault = 1'b1;
                end
            end
            ST_RSP: begin
                if (dmem_rvalid_i) begin
                    state_d = ST_DONE;
                    capture = 1'b1;
                end else if (expired) begin
                    state_d  = ST_DONE;
                    to_fault = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // state, request fields, timeout counter and load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= RESET_ADDR;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= 32'h0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            load_q  <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= to_fault;
            if (start) begin
                cnt_q   <= 8'd0;
                addr_q  <= {mem_addr_i[31:2], 2'b00};
                we_q    <= mem_write_i;
                be_q    <= fmt_be;
                wdata_q <= fmt_wdata;
                f3_q    <= funct3_i;
                off_q   <= mem_addr_i[1:0];
            end else if (state_q == ST_REQ || state_q == ST_RSP) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (capture) begin
                load_q <= fmt_load;
            end else if (to_fault) begin
                load_q <= 32'h0;
            end
        end
    end

    assign dmem_req_o     = (state_q == ST_REQ);
    assign dmem_we_o      = dmem_req_o & we_q;
    assign dmem_addr_o    = idle ? RESET_ADDR : addr_q;
    assign dmem_be_o      = dmem_req_o ? be_q : 4'b0000;
    assign dmem_wdata_o   = dmem_req_o ? wdata_q : 32'h0;
    assign load_data_o    = load_q;
    assign mem_done_o     = (state_q == ST_DONE);
    assign access_fault_o = mem_done_o & fault_q;
    assign misalign_o     = idle & op & fmt_mis & ~flush_i;
    assign stall_o        = start | (state_q == ST_REQ)
                          | (state_q == ST_RSP);

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage load/store unit sitting directly downstream of the EX/MEM pipeline register, consuming its address, store data, funct3 and memory control outputs.
- Runs a req/gnt/rvalid handshake with the data memory and formats byte, half and word accesses, including load sign/zero extension.
- Raises stall_o to freeze the pipeline until the access completes.
- Passes the formatted load data and a fault indication toward the MEM/WB register.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles spent in REQ+RSP before access fault; 8-bit counter, legal 1..255.
- RESET_ADDR, 32'h0, value driven on dmem_addr_o while idle/reset.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous active-high reset
- flush_i  input  1  pipeline flush; sampled only in IDLE
- mem_addr_i  input  32  effective address (EX result from EX/MEM)
- store_data_i  input  32  rs2 data from EX/MEM
- funct3_i  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- mem_read_i  input  1  load request from EX/MEM
- mem_write_i  input  1  store request from EX/MEM
- dmem_req_o  output  1  bus request
- dmem_we_o  output  1  1=write
- dmem_addr_o  output  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be_o  output  4  byte enables
- dmem_wdata_o  output  32  lane-replicated store data
- dmem_gnt_i  input  1  request accepted
- dmem_rvalid_i  input  1  read data valid
- dmem_rdata_i  input  32  read word
- load_data_o  output  32  formatted load result
- mem_done_o  output  1  one-cycle pulse: access finished (incl. fault)
- misalign_o  output  1  one-cycle pulse: misaligned access, no bus cycle
- access_fault_o  output  1  one-cycle pulse: bus timeout
- stall_o  output  1  hold IF/ID/EX/MEM while high

Behaviour:
- Reset (async, rst=1): state=IDLE; dmem_req_o=0, dmem_we_o=0, dmem_addr_o=RESET_ADDR, dmem_be_o=0, dmem_wdata_o=0, load_data_o=0, mem_done_o=0, misalign_o=0, access_fault_o=0, timeout counter=0.
- stall_o is combinational: (state==IDLE & op & aligned & !flush_i) | state==REQ | state==RSP; op = mem_read_i|mem_write_i.
- Alignment: word requires addr[1:0]=00; half requires addr[0]=0; byte is always aligned. funct3 values 011, 110, 111 are treated as misaligned (illegal).
- Byte enables: byte=4'b0001<<addr[1:0]; half=4'b0011<<addr[1:0]; word=4'b1111.
- Store data: byte data is replicated to all 4 lanes; half data is replicated to both halves.
- States:
  - IDLE: op & misaligned & !flush_i -> misalign_o=1 for 1 cycle, stay IDLE, no bus cycle, stall_o=0. op & aligned & !flush_i -> latch addr/we/be/wdata/funct3/addr[1:0], go REQ. flush_i or no op -> stay IDLE.
  - REQ: dmem_req_o=1 with latched fields held stable until gnt. On gnt: write -> DONE; read -> RSP. Same-cycle gnt+rvalid on a read -> capture data, go DONE directly.
  - RSP: dmem_req_o=0. On rvalid: extract lane by latched addr[1:0], sign/zero-extend per funct3 into load_data_o, go DONE.
  - DONE: mem_done_o=1, stall_o=0, so EX/MEM advances at the end of this cycle; go IDLE unconditionally. A new op seen next cycle in IDLE is a new instruction.
- Timeout: counter clears on entry to REQ and increments each cycle in REQ/RSP. When it reaches TIMEOUT_CYCLES: go DONE with access_fault_o=1, load_data_o=0, dmem_req_o dropped.
- Latency with zero-wait memory:
  - store: 3 cycles (IDLE, REQ, DONE), stall high 2 cycles.
  - load with gnt then rvalid next cycle: 4 cycles.
- Flush is ignored in REQ/RSP: a granted or pending request completes. Pipeline control must not flush EX/MEM while stall_o=1.
- load_data_o holds its value until the next load completes. Stores do not change it.
- Reset asserted mid-transaction aborts immediately: req drops and any late rvalid/gnt is ignored in IDLE.

Decomposition:
- Shared package defines.v holds:
  - funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW)
  - state encodings (IDLE=2'd0, REQ=1, RSP=2, DONE=3)
  - DEFAULT_TIMEOUT
- One natural sub-module: lsu_align_format, a combinational block computing be, wdata replication, misalign and load extraction/extension. The FSM stays in mem_access_stage.

Test Plan:
- SW addr=0x104, data=0xDEADBEEF, gnt same cycle as req -> be=1111, addr=0x104, wdata=0xDEADBEEF; stall high 2 cycles, mem_done_o pulse in cycle 3.
- LB addr=0x203, rdata=0x80FF_FF7F, rvalid 1 cycle after gnt -> load_data_o=0xFFFFFF80; LBU same -> 0x00000080.
- LH addr=0x102 with rdata=0x8001_1234 -> 0xFFFF8001. LW addr=0x102 -> misalign_o pulse, dmem_req_o never asserted, stall_o=0.
- SB addr=0x3, data=0x000000AB -> be=1000, wdata=0xABABABAB. gnt withheld 3 cycles -> req and fields stable throughout.
- TIMEOUT_CYCLES=4, load, gnt never returned -> access_fault_o after 4 REQ cycles, load_data_o=0, FSM returns to IDLE.
- rst pulsed while in RSP, then rvalid arrives -> outputs at reset values; rvalid ignored; next LW proceeds normally.
